pb_cond: RTL and testbench
==========================

Name: pb_cond

Overview:
- Multi-channel push-button conditioner: per-channel synchroniser, counter-based debounce, registered edge pulses and long-press/auto-repeat detection.
- Sits between raw board button pins and the control FSMs. Replaces single-channel rise detectors.
- Consumers see clean one-cycle press/release/long strobes plus a debounced level.

Parameters:
- NUM_CH, 4, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flop count per channel (legal: >=2).
- DB_CYC, 16, consecutive stable cycles needed before the debounced level changes (legal: >=1).
- ACTIVE_LOW, 1, 1: pressed = pin low; 0: pressed = pin high.
- LONG_CYC, 50000000, pressed cycles before the first long strobe (legal: >=1).
- REPEAT_CYC, 0, 0: single long strobe per press; >0: further long strobes every REPEAT_CYC cycles while held.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pb  in  NUM_CH  raw asynchronous button pins.
- pressed  out  NUM_CH  debounced level, 1 = button held.
- press  out  NUM_CH  one-cycle strobe on debounced press.
- release  out  NUM_CH  one-cycle strobe on debounced release.
- long  out  NUM_CH  one-cycle long-press / repeat strobe.

Behaviour:
- Channels are fully independent. No shared state.
- Reset:
  - Synchroniser flops and the debounced level reset to the idle pin value (1 if ACTIVE_LOW, else 0).
  - All counters reset to 0.
  - pressed, press, release and long reset to 0.
  - Asserting rst_n mid-debounce or mid-hold aborts with no strobe.
- Synchroniser: the pin is delayed by SYNC_STAGES flops. No logic between stages.
- Debounce:
  - On each cycle where the sync output differs from the debounced level, the counter increments.
  - On any cycle where they match, the counter clears to 0.
  - When the counter would reach DB_CYC, the debounced level takes the sync value and the counter clears.
  - Glitches shorter than DB_CYC cycles never reach the outputs.
- Strobes:
  - press/release/long are registered.
  - press is high for exactly one cycle, the cycle after the debounced level enters the pressed state. release behaves the same on leaving it.
  - pressed is registered and aligned with press/release: it rises in the same cycle as press and falls in the same cycle as release.
  - Latency from the first clock edge sampling a stable new pin value to the strobe: SYNC_STAGES + DB_CYC + 1 cycles.
- Hold counter:
  - Counts while pressed=1 and clears on the cycle release asserts.
  - long asserts one cycle when the count reaches LONG_CYC.
  - If REPEAT_CYC>0, long also asserts every REPEAT_CYC cycles afterwards while held.
  - If REPEAT_CYC=0, the counter saturates after the first long strobe (no wrap, no re-fire).
- Widths:
  - Debounce counter width: $clog2(DB_CYC+1).
  - Hold counter width: $clog2(LONG_CYC+REPEAT_CYC+1).
  - No overflow is permitted at any legal parameter value.
- Simultaneous events:
  - Release on the same cycle the hold count would hit a long threshold: release wins, long is suppressed.
  - press and release never both assert on one channel in the same cycle.
  - Several channels may strobe in the same cycle.

Test Plan:
Config for all scenarios: NUM_CH=4, SYNC_STAGES=2, DB_CYC=4, ACTIVE_LOW=1, LONG_CYC=20, REPEAT_CYC=8.
- Reset, pb=4'hF held for 30 cycles -> all outputs 0 throughout. Assert rst_n low mid-run -> outputs 0 immediately, asynchronously.
- pb[0] 1->0 and held -> press[0] pulses exactly 7 cycles after the first sampling edge; pressed[0]=1 from that cycle. Set pb[0]=1 -> release[0] pulses 7 cycles later and pressed[0] falls with it.
- pb[1] pulsed low for 3 cycles, repeated 5 times with 2-cycle gaps -> no press[1]; counter clears on each gap.
- pb[2] held low for 50 cycles after press -> long[2] pulses at hold counts 20, 28, 36, 44 (4 strobes); release[2] pulses once on release.
- Rerun with REPEAT_CYC=0 and the same stimulus -> exactly one long strobe.
- All 4 channels pressed on the same edge -> all press bits pulse in the same cycle. Release ch3 timed so release coincides with hold count 20 -> long[3]=0 and release[3]=1.
- Reset asserted 2 cycles into a 4-cycle debounce on ch0 -> no press[0] after rst_n is released, even with pb held low for a further 3 cycles.

Source files
------------

// File: rtl/pb_cond.sv
// Multi-channel push-button conditioner: synchroniser, counter debounce, press/release/long strobes.
// Latency pin->strobe SYNC_STAGES+DB_CYC+1 cycles; no backpressure, strobes are fire-and-forget.
module pb_cond #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYC      = 16,
  parameter int ACTIVE_LOW  = 1,
  parameter int LONG_CYC    = 50000000,
  parameter int REPEAT_CYC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb,
  output logic [NUM_CH-1:0] pressed,
  output logic [NUM_CH-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [NUM_CH-1:0] release_stb,
  output logic [NUM_CH-1:0] long
);

  localparam logic IDLE     = (ACTIVE_LOW != 0);
  localparam int   DW       = $clog2(DB_CYC + 1);
  localparam int   HOLD_MAX = LONG_CYC + REPEAT_CYC;
  localparam int   HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);
  localparam logic [HW-1:0] LONG_V  = HW'(LONG_CYC);
  localparam logic [HW-1:0] WRAP_V  = HW'(HOLD_MAX);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   db_lvl;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [HW-1:0]          hold_nx;
    logic                   act;
    logic                   pressed_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;

    assign act     = db_lvl ^ IDLE;
    assign hold_nx = hold_cnt + HW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{IDLE}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pb[c]};
      end
    end

    // Level only moves after DB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_lvl <= IDLE;
        db_cnt <= '0;
      end else if (sync_q[SYNC_STAGES-1] == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= sync_q[SYNC_STAGES-1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        hold_cnt  <= '0;
      end else begin
        pressed_q <= act;
        press_q   <= act & ~pressed_q;
        release_q <= ~act & pressed_q;
        // A falling level on a threshold cycle clears the count, so release beats long.
        if (!(pressed_q && act)) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else if (REPEAT_CYC == 0 && hold_cnt == LONG_V) begin
          long_q   <= 1'b0;
        end else if (REPEAT_CYC > 0 && hold_nx == WRAP_V) begin
          hold_cnt <= LONG_V;
          long_q   <= 1'b1;
        end else begin
          hold_cnt <= hold_nx;
          long_q   <= (hold_nx == LONG_V);
        end
      end
    end

    assign pressed[c]     = pressed_q;
    assign press[c]       = press_q;
    assign release_stb[c] = release_q;
    assign long[c]        = long_q;
  end

endmodule

// File: tb/tb_pb_cond.sv
// Bench for pb_cond: directed scenarios plus random pin activity, checked against a history-based model.
module tb_pb_cond;
  localparam int   NCH   = 4;
  localparam int   SYNC  = 2;
  localparam int   DB    = 4;
  localparam int   LONGC = 20;
  localparam int   REP   = 8;
  localparam logic IDLE  = 1'b1;
  localparam int   MAXC  = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] pb = 4'hF;
  logic [3:0] pressed_a, press_a, rel_a, long_a;
  logic [3:0] pressed_b, press_b, rel_b, long_b;

  pb_cond #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .DB_CYC(DB), .ACTIVE_LOW(1),
            .LONG_CYC(LONGC), .REPEAT_CYC(REP)) u_rep (
    .clk(clk), .rst_n(rst_n), .pb(pb), .pressed(pressed_a), .press(press_a),
    .release_stb(rel_a), .long(long_a));

  pb_cond #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .DB_CYC(DB), .ACTIVE_LOW(1),
            .LONG_CYC(LONGC), .REPEAT_CYC(0)) u_single (
    .clk(clk), .rst_n(rst_n), .pb(pb), .pressed(pressed_b), .press(press_b),
    .release_stb(rel_b), .long(long_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_last = 0;
  logic [3:0] pbh [MAXC];
  logic lvl [NCH];
  logic prs_b [NCH];
  int pstart [NCH];
  logic [3:0] e_pressed, e_press, e_rel, e_long_a, e_long_b;

  task automatic chk4(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Synchroniser output seen after edge t: the pin captured SYNC-1 edges earlier, idle if wiped by reset.
  function automatic logic sync_after(int t, int c);
    int s;
    s = t - (SYNC - 1);
    if (s <= rst_last || s < 0 || s >= MAXC) return IDLE;
    return pbh[s][c];
  endfunction

  function automatic bit fires(int k, int rep);
    if (k == LONGC) return 1'b1;
    if (rep > 0 && k > LONGC && (k - LONGC) % rep == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      lvl[c] = IDLE;
      prs_b[c] = 1'b0;
    end
    e_pressed = '0; e_press = '0; e_rel = '0; e_long_a = '0; e_long_b = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      logic act;
      bit flip;
      act = (lvl[c] != IDLE);
      e_pressed[c] = act;
      e_press[c]   = act && !prs_b[c];
      e_rel[c]     = !act && prs_b[c];
      e_long_a[c]  = prs_b[c] && act && fires(cyc - pstart[c], REP);
      e_long_b[c]  = prs_b[c] && act && fires(cyc - pstart[c], 0);
      if (e_press[c]) pstart[c] = cyc;
      flip = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (sync_after(cyc - j, c) == lvl[c]) flip = 1'b0;
      if (flip) lvl[c] = !lvl[c];
      prs_b[c] = act;
    end
  endtask

  task automatic check_all();
    chk4("pressed_rep", pressed_a, e_pressed);
    chk4("press_rep", press_a, e_press);
    chk4("release_rep", rel_a, e_rel);
    chk4("long_rep", long_a, e_long_a);
    chk4("pressed_single", pressed_b, e_pressed);
    chk4("press_single", press_b, e_press);
    chk4("release_single", rel_b, e_rel);
    chk4("long_single", long_b, e_long_b);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      rst_last = cyc;
      model_reset();
    end else begin
      if (cyc < MAXC) pbh[cyc] = pb;
      model_step();
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    rst_last = cyc;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, dly, cnt_a, cnt_b, cnt_r, cnt_p;
    int run [NCH];
    for (int c = 0; c < NCH; c++) pstart[c] = 0;
    model_reset();
    rst_n = 1'b0;
    pb = 4'hF;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk4("idle_pressed", pressed_a, 4'h0);

    // Single press on ch0: latency and level alignment.
    pb[0] = 1'b0; t0 = cyc; dly = -1;
    for (int i = 0; i < 20 && dly < 0; i++) begin
      tick();
      if (press_a[0]) dly = cyc - t0;
    end
    chki("press_latency", dly, 7);
    chk1("pressed_with_press", pressed_a[0], 1'b1);
    repeat (10) tick();
    pb[0] = 1'b1; t0 = cyc; dly = -1;
    for (int i = 0; i < 20 && dly < 0; i++) begin
      tick();
      if (rel_a[0]) dly = cyc - t0;
    end
    chki("release_latency", dly, 7);
    chk1("pressed_falls", pressed_a[0], 1'b0);
    repeat (5) tick();

    // Short glitches on ch1.
    cnt_p = 0;
    for (int g = 0; g < 5; g++) begin
      pb[1] = 1'b0;
      repeat (3) begin tick(); cnt_p += int'(press_a[1]); end
      pb[1] = 1'b1;
      repeat (2) begin tick(); cnt_p += int'(press_a[1]); end
    end
    repeat (10) begin tick(); cnt_p += int'(press_a[1]); end
    chki("glitch_no_press", cnt_p, 0);

    // Long hold on ch2.
    cnt_a = 0; cnt_b = 0; cnt_r = 0;
    pb[2] = 1'b0;
    repeat (50) begin
      tick();
      cnt_a += int'(long_a[2]); cnt_b += int'(long_b[2]); cnt_r += int'(rel_a[2]);
    end
    pb[2] = 1'b1;
    repeat (15) begin
      tick();
      cnt_a += int'(long_a[2]); cnt_b += int'(long_b[2]); cnt_r += int'(rel_a[2]);
    end
    chki("long_repeat_count", cnt_a, 4);
    chki("long_single_count", cnt_b, 1);
    chki("release2_count", cnt_r, 1);

    // All channels together; ch3 released exactly on the first long threshold.
    pb = 4'h0; t0 = cyc; dly = -1;
    for (int i = 0; i < 20 && dly < 0; i++) begin
      tick();
      if (press_a != 4'h0) begin
        dly = cyc - t0;
        chk4("press_all_same_cycle", press_a, 4'hF);
      end
    end
    chki("press_all_latency", dly, 7);
    repeat (13) tick();
    pb[3] = 1'b1;
    repeat (7) tick();
    chk1("release3_on_threshold", rel_a[3], 1'b1);
    chk1("long3_suppressed", long_a[3], 1'b0);
    chk4("long_others", {1'b0, long_a[2:0]}, 4'h7);
    repeat (5) tick();
    async_reset();
    chk4("async_reset_pressed", pressed_a, 4'h0);
    pb = 4'hF;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // Reset in the middle of a debounce on ch0.
    pb[0] = 1'b0;
    repeat (3) tick();
    async_reset();
    tick();
    rst_n = 1'b1;
    cnt_p = 0;
    repeat (3) begin tick(); cnt_p += int'(press_a[0]); end
    pb[0] = 1'b1;
    repeat (15) begin tick(); cnt_p += int'(press_a[0]); end
    chki("reset_abort_no_press", cnt_p, 0);

    // Random pin activity on all channels.
    for (int c = 0; c < NCH; c++) run[c] = $urandom_range(1, 45);
    repeat (1500) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        run[c]--;
        if (run[c] == 0) begin
          pb[c] = ~pb[c];
          run[c] = $urandom_range(1, 45);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
